vdb_mem_read_arbiter: RTL

//  Round-robin arbiter sharing the single vector-DB memory read port (mem_rd_*) among
//  NUM_REQ burst requesters: retrieval engines, vector-cache refill and metadata fetch.

---
 rtl/vdb_mem_read_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vdb_mem_read_arbiter.sv
// Round-robin arbiter sharing one burst memory read port among NUM_REQ requesters.
// Optional stall watchdog enabled by defining VDB_ARB_TIMEOUT_EN.
module vdb_mem_read_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned BUS_WIDTH      = 512,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0][31:0]          req_addr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]     req_beats,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [BUS_WIDTH-1:0]              rsp_data,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [NUM_REQ-1:0]                rsp_last,
    output logic                              mem_rd_en,
    output logic [31:0]                       mem_rd_addr,
    input  logic [BUS_WIDTH-1:0]              mem_rd_data,
    input  logic                              mem_rd_valid,
    output logic                              busy,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              err_timeout
);

    localparam int unsigned ID_W      = $clog2(NUM_REQ);
    localparam int unsigned ADDR_STEP = BUS_WIDTH / 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_STREAM
    } state_e;

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    grant_q;
    logic [31:0]        addr_q;
    logic [LEN_W-1:0]   beats_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic               rd_en_q;
    logic               busy_q;

    logic               pick_found_d;
    logic [ID_W-1:0]    pick_d;
    int unsigned        idx;
    logic               beat_c;
    logic               last_c;
    logic               timeout_c;
    logic [ID_W-1:0]    next_ptr_c;
    logic [NUM_REQ-1:0] grant_oh_c;

    // First requester at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick_found_d = 1'b0;
        pick_d       = '0;
        idx          = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found_d && req_valid[ID_W'(idx)]) begin
                pick_found_d = 1'b1;
                pick_d       = ID_W'(idx);
            end
        end
    end

    assign beat_c     = (state_q == ARB_STREAM) && mem_rd_valid;
    assign last_c     = (cnt_q == beats_q - LEN_W'(1));
    assign next_ptr_c = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + ID_W'(1);
    assign grant_oh_c = NUM_REQ'(1) << grant_q;

    // Beat return path is combinational so requesters see data with no added latency.
    assign rsp_data  = mem_rd_data;
    assign rsp_valid = beat_c ? grant_oh_c : '0;
    assign rsp_last  = (beat_c && last_c) ? grant_oh_c : '0;

`ifdef VDB_ARB_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q;
    logic               err_q;

    assign timeout_c = (state_q == ARB_STREAM) && !mem_rd_valid &&
                       (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

    // Stall watchdog: counts beat-less streaming cycles, cleared while idle or on a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout_c;
            if ((state_q != ARB_STREAM) || mem_rd_valid || timeout_c) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign timeout_c   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Arbitration and burst sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            beats_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            req_ready_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found_d) begin
                        grant_q     <= pick_d;
                        addr_q      <= req_addr[pick_d];
                        beats_q     <= (req_beats[pick_d] == '0) ? LEN_W'(1) : req_beats[pick_d];
                        cnt_q       <= '0;
                        req_ready_q <= NUM_REQ'(1) << pick_d;
                        rd_en_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ARB_STREAM;
                    end
                end
                ARB_STREAM: begin
                    if (beat_c) begin
                        cnt_q  <= cnt_q + LEN_W'(1);
                        addr_q <= addr_q + 32'(ADDR_STEP);
                    end
                    if ((beat_c && last_c) || timeout_c) begin
                        rd_en_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= next_ptr_c;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = addr_q;
    assign busy        = busy_q;
    assign grant_id    = grant_q;

endmodule
